// File: rtl/alu32_core.sv
// 32-bit ALU with a single registered output stage: add/sub, compares and shifts.
// Outputs hold their previous values on idle cycles; out_valid marks fresh results.
module alu32_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   opCode,
    output logic             out_valid,
    output logic [WIDTH-1:0] ans1,
    output logic             ans2,
    output logic             Z,
    output logic             N,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OpAdd = OPW'(6'b000000);
    localparam logic [OPW-1:0] OpSub = OPW'(6'b000001);
    localparam logic [OPW-1:0] OpEq  = OPW'(6'b100000);
    localparam logic [OPW-1:0] OpNe  = OPW'(6'b100001);
    localparam logic [OPW-1:0] OpLe  = OPW'(6'b100010);
    localparam logic [OPW-1:0] OpGt  = OPW'(6'b100011);
    localparam logic [OPW-1:0] OpLls = OPW'(6'b110000);
    localparam logic [OPW-1:0] OpArs = OPW'(6'b110001);
    localparam logic [OPW-1:0] OpLrs = OPW'(6'b110010);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ill;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] ans1_d, ans1_q;
    logic             ans2_d, ans2_q;
    logic             z_d, z_q;
    logic             n_d, n_q;
    logic             illegal_d, illegal_q;

    // Extra top bit of the widened add/sub is the carry-out / borrow.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shamt    = b[SHW-1:0];

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ill   = 1'b0;
        case (opCode)
            OpAdd: begin
                res   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
            end
            OpSub: begin
                res   = diff_ext[WIDTH-1:0];
                carry = diff_ext[WIDTH];
            end
            OpEq:    res = {{(WIDTH-1){1'b0}}, (a == b)};
            OpNe:    res = {{(WIDTH-1){1'b0}}, (a != b)};
            OpLe:    res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
            OpGt:    res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OpLls:   res = a << shamt;
            OpLrs:   res = a >> shamt;
            OpArs:   res = WIDTH'($signed(a) >>> shamt);
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = in_valid;
        ans1_d      = ans1_q;
        ans2_d      = ans2_q;
        z_d         = z_q;
        n_d         = n_q;
        illegal_d   = illegal_q;
        if (in_valid) begin
            ans1_d    = res;
            ans2_d    = carry;
            z_d       = (res == '0);
            n_d       = res[WIDTH-1];
            illegal_d = ill;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ans1_q      <= '0;
            ans2_q      <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ans1_q      <= ans1_d;
            ans2_q      <= ans2_d;
            z_q         <= z_d;
            n_q         <= n_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ans1      = ans1_q;
    assign ans2      = ans2_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu32_core.sv
// Bench for alu32_core: opcode-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu32_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  opc;
    logic        out_valid;
    logic [31:0] ans1;
    logic        ans2;
    logic        z;
    logic        n;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    alu32_core #(.WIDTH(32), .OPW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .opCode    (opc),
        .out_valid (out_valid),
        .ans1      (ans1),
        .ans2      (ans2),
        .Z         (z),
        .N         (n),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        ill;
    } res_t;

    function automatic res_t model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        res_t            o;
        longint unsigned s;
        int              sx;
        int              sy;
        int unsigned     sh;
        o  = '0;
        sx = x;
        sy = y;
        sh = y % 32;
        case (op)
            6'b000000: begin
                s   = longint'(x) + longint'(y);
                o.r = s[31:0];
                o.c = (s >= 64'h1_0000_0000);
            end
            6'b000001: begin
                o.r = x - y;
                o.c = (x < y);
            end
            6'b100000: o.r = (x == y) ? 32'd1 : 32'd0;
            6'b100001: o.r = (x != y) ? 32'd1 : 32'd0;
            6'b100010: o.r = (sx <= sy) ? 32'd1 : 32'd0;
            6'b100011: o.r = (sx > sy) ? 32'd1 : 32'd0;
            6'b110000: o.r = x << sh;
            6'b110010: o.r = x >> sh;
            6'b110001: o.r = sx >>> sh;
            default:   o.ill = 1'b1;
        endcase
        return o;
    endfunction

    // Expected registered outputs, advanced on every rising edge.
    logic        e_init = 1'b0;
    logic        e_valid, e_c, e_z, e_n, e_ill;
    logic [31:0] e_r;
    res_t        m;

    always @(posedge clk) begin
        m = model(opc, a, b);
        if (!rst_n) begin
            e_init  <= 1'b1;
            e_valid <= 1'b0;
            e_r     <= '0;
            e_c     <= 1'b0;
            e_z     <= 1'b0;
            e_n     <= 1'b0;
            e_ill   <= 1'b0;
        end else if (in_valid) begin
            e_valid <= 1'b1;
            e_r     <= m.r;
            e_c     <= m.c;
            e_z     <= (m.r == 32'd0);
            e_n     <= m.r[31];
            e_ill   <= m.ill;
        end else begin
            e_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (e_init) begin
            tests++;
            if ({out_valid, ans1, ans2, z, n, illegal} !== {e_valid, e_r, e_c, e_z, e_n, e_ill}) begin
                fails++;
                $display("FAIL model_cmp t=%0t got v=%b r=%h c=%b z=%b n=%b ill=%b want v=%b r=%h c=%b z=%b n=%b ill=%b",
                         $time, out_valid, ans1, ans2, z, n, illegal,
                         e_valid, e_r, e_c, e_z, e_n, e_ill);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] r,
                              input logic c, input logic zz, input logic nn, input logic il);
        chk({name, ".valid"},   {31'd0, out_valid}, {31'd0, v});
        chk({name, ".ans1"},    ans1, r);
        chk({name, ".ans2"},    {31'd0, ans2}, {31'd0, c});
        chk({name, ".Z"},       {31'd0, z}, {31'd0, zz});
        chk({name, ".N"},       {31'd0, n}, {31'd0, nn});
        chk({name, ".illegal"}, {31'd0, illegal}, {31'd0, il});
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        opc      = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opc      = '0;
        a        = '0;
        b        = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        issue(6'b110001, 32'h0001_0000, 32'h1);
        expect_out("ars1", 1'b1, 32'h0000_8000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(6'b110001, 32'h8000_0000, 32'h4);
        expect_out("ars_sign", 1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(6'b110001, 32'h8000_0000, 32'h24);
        expect_out("ars_mask", 1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(6'b110010, 32'h8000_0000, 32'h4);
        expect_out("lrs", 1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(6'b110000, 32'hDEAD_BEEF, 32'h20);
        expect_out("lls_zero", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);

        issue(6'b100000, 32'h1234, 32'h1234);
        expect_out("eq_t", 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(6'b100000, 32'h1234, 32'h1235);
        expect_out("eq_f", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(6'b100001, 32'h1234, 32'h1235);
        expect_out("ne_t", 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(6'b100011, 32'hFFFF_FFFF, 32'h1);
        expect_out("gt_signed", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(6'b100010, 32'h5, 32'h5);
        expect_out("le_eq", 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(6'b000000, 32'hFFFF_FFFF, 32'h1);
        expect_out("add_carry", 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(6'b000001, 32'h1, 32'h2);
        expect_out("sub_borrow", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(6'b000001, 32'h5, 32'h5);
        expect_out("sub_zero", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        issue(6'b000000, 32'h3, 32'h4);
        expect_out("pipe_add", 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(6'b000001, 32'h10, 32'h3);
        expect_out("pipe_sub", 1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(6'b110000, 32'h1, 32'h1F);
        expect_out("pipe_lls", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        expect_out("hold", 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(6'b111111, 32'h5, 32'h5);
        expect_out("illegal", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        issue(6'b000000, 32'hFFFF_FFFF, 32'h2);
        expect_out("pre_rst", 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        issue(6'b000000, 32'h1, 32'h2);
        expect_out("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        issue(6'b000000, 32'h1, 32'h2);
        expect_out("post_rst", 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu32_core.md
Name: alu32_core

Overview:
- 32-bit registered ALU for the datapath.
- Covers add, subtract, equality, inequality, signed compare, logical shifts and arithmetic right shift, selected by a 6-bit opcode.
- Produces a 32-bit result, a carry/borrow bit, and zero/negative flags.
- Sits between the register-file read stage and write-back; result is registered with one-cycle latency.

Parameters:
- WIDTH, 32, operand/result width; shift amount uses the low log2(WIDTH) bits of b.
- OPW, 6, opcode width.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands/opcode valid this cycle.
- a  input  32  operand A.
- b  input  32  operand B, or shift amount in b[4:0].
- opCode  input  6  operation select.
- out_valid  output  1  ans1/ans2/Z/N/illegal hold a new result.
- ans1  output  32  result.
- ans2  output  1  carry out (ADD) or borrow (SUB); 0 for all other ops.
- Z  output  1  1 when ans1 == 0.
- N  output  1  equals ans1[31].
- illegal  output  1  opcode not in map.

Behaviour:
- Reset: on a rising clk with rst_n=0, the next-cycle outputs are:
  - ans1=0, ans2=0, Z=0, N=0, illegal=0, out_valid=0.
  - Reset overrides in_valid; an operation in flight is discarded.
- Latency:
  - If in_valid=1 at edge k, results appear after edge k with out_valid=1.
  - Back-to-back issue is allowed every cycle.
  - No backpressure.
- If in_valid=0 at an edge: out_valid=0, all other outputs hold their previous values.
- Opcode map (all others are illegal: ans1=0, ans2=0, Z=1, N=0, illegal=1):
  - 000000 ADD: ans1=a+b mod 2^32; ans2=carry out of bit 31.
  - 000001 SUB: ans1=a-b mod 2^32; ans2=1 iff a<b unsigned (borrow).
  - 100000 EQ: ans1={31'b0, a==b}.
  - 100001 NE: ans1={31'b0, a!=b}.
  - 100010 LE: ans1={31'b0, signed(a)<=signed(b)}.
  - 100011 GT: ans1={31'b0, signed(a)>signed(b)}.
  - 110000 LLS: ans1=a << b[4:0], zero fill.
  - 110010 LRS: ans1=a >> b[4:0], zero fill.
  - 110001 ARS: ans1=a >>> b[4:0], sign fill from a[31].
- Shifts: b[31:5] ignored; shift by 0 returns a unchanged.
- Flags:
  - Z and N are computed from the registered ans1 value for every op, compares included.
  - illegal=0 for mapped opcodes.
- Signed overflow is not flagged.
- Combinational compute path (adder/subtractor, comparators, barrel shifter) feeds one output register stage.
- No internal state besides the output registers.

Test Plan:
1. ARS: rst_n=1, in_valid=1, opCode=110001, a=0x00010000, b=0x00000001 -> next cycle ans1=0x00008000, ans2=0, Z=0, N=0, out_valid=1, illegal=0.
2. ARS sign fill and shift-field masking:
   - a=0x80000000, b=4 -> ans1=0xF8000000, N=1.
   - b=0x00000024 -> same as shift by 4.
   - LRS with the same a, b=4 -> 0x08000000.
3. EQ/NE/compare:
   - EQ a=b=0x1234 -> ans1=1, Z=0.
   - EQ a=0x1234, b=0x1235 -> ans1=0, Z=1.
   - GT a=0xFFFFFFFF, b=1 -> ans1=0 (signed).
   - LE a=5, b=5 -> ans1=1.
4. ADD/SUB boundaries:
   - ADD 0xFFFFFFFF+1 -> ans1=0, ans2=1, Z=1.
   - SUB 1-2 -> ans1=0xFFFFFFFF, ans2=1, N=1.
   - SUB 5-5 -> ans1=0, ans2=0, Z=1.
5. Pipelining and hold:
   - Issue ADD, SUB, LLS on three consecutive cycles -> three consecutive correct results with out_valid=1.
   - Then in_valid=0 -> out_valid=0, ans1 holds the LLS result.
   - Opcode 111111 -> illegal=1, ans1=0, Z=1.
6. Reset mid-operation: rst_n=0 on the same edge as in_valid=1 ADD -> next cycle all outputs 0, out_valid=0; releasing rst_n resumes normal one-cycle operation.
